// File: rtl/lcd_spi_writer_if.sv
// Request/completion bus for lcd_spi_writer.
//   en_i   [1:0] one-cycle request strobes: [0] panel reset, [1] byte write
//   data_i [8:0] write payload: [8] D/C (1 = data, 0 = command), [7:0] byte
//   done_o [1:0] one-cycle completion pulses: [0] reset sequence, [1] byte write
// master: the requester; slave: the writer.
interface lcd_spi_writer_if;
  logic [1:0] en_i;
  logic [8:0] data_i;
  logic [1:0] done_o;

  modport master (output en_i, output data_i, input done_o);
  modport slave  (input en_i, input data_i, output done_o);
endinterface

// File: rtl/lcd_spi_writer.sv
// SPI writer for an LCD panel: runs the panel hardware-reset sequence and
// shifts single command/data bytes out in SPI mode 0, MSB first.
// Ports:
//   clk, rst    single rising-edge clock, synchronous active-high reset
//   bus         lcd_spi_writer_if.slave (en_i, data_i, done_o)
//   busy_o      high in every state except IDLE (only with LCD_SPI_BUSY_EN)
//   lcd_rst_o   panel reset, active low
//   lcd_cs_o    chip select, active low
//   lcd_dc_o    D/C line, holds the last written value
//   lcd_sclk_o  SPI clock, idles low
//   lcd_mosi_o  SPI data
// Optional feature macro: LCD_SPI_BUSY_EN adds the busy_o output.
// Parameters: CLK_DIV (clk cycles per SCLK half-period, 1..255),
//   RST_LOW_CYC (cycles lcd_rst_o is held low), RST_WAIT_CYC (cycles
//   waited after lcd_rst_o rises before done_o[0]).
module lcd_spi_writer #(
  parameter int CLK_DIV      = 2,
  parameter int RST_LOW_CYC  = 50_000,
  parameter int RST_WAIT_CYC = 6_000_000
) (
  input  logic              clk,
  input  logic              rst,
  lcd_spi_writer_if.slave   bus,
`ifdef LCD_SPI_BUSY_EN
  output logic              busy_o,
`endif
  output logic              lcd_rst_o,
  output logic              lcd_cs_o,
  output logic              lcd_dc_o,
  output logic              lcd_sclk_o,
  output logic              lcd_mosi_o
);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, SHIFT, FINISH} state_t;

  // Terminal counts; counters start at 0, so the last cycle is N-1.
  localparam logic [27:0] LOW_LAST  = 28'(RST_LOW_CYC - 1);
  localparam logic [27:0] WAIT_LAST = 28'(RST_WAIT_CYC - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);

  state_t      state;
  logic [27:0] dly_cnt;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      bus.done_o <= 2'b00;
      lcd_rst_o  <= 1'b1;
      lcd_cs_o   <= 1'b1;
      lcd_dc_o   <= 1'b0;
      lcd_sclk_o <= 1'b0;
      lcd_mosi_o <= 1'b0;
    end else begin
      bus.done_o <= 2'b00;
      case (state)
        IDLE: begin
          // Reset request has priority; a simultaneous write is dropped.
          if (bus.en_i[0]) begin
            state     <= RST_LOW;
            lcd_rst_o <= 1'b0;
            dly_cnt   <= '0;
            busy      <= 1'b1;
          end else if (bus.en_i[1]) begin
            state      <= SHIFT;
            lcd_cs_o   <= 1'b0;
            lcd_dc_o   <= bus.data_i[8];
            lcd_mosi_o <= bus.data_i[7];
            shreg      <= {bus.data_i[6:0], 1'b0};
            lcd_sclk_o <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
          end
        end
        RST_LOW: begin
          if (dly_cnt == LOW_LAST) begin
            state     <= RST_WAIT;
            lcd_rst_o <= 1'b1;
            dly_cnt   <= '0;
          end else begin
            dly_cnt <= dly_cnt + 28'd1;
          end
        end
        RST_WAIT: begin
          if (dly_cnt == WAIT_LAST) begin
            state      <= IDLE;
            bus.done_o <= 2'b01;
            dly_cnt    <= '0;
            busy       <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt + 28'd1;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!lcd_sclk_o) begin
              lcd_sclk_o <= 1'b1;
            end else begin
              // End of a high phase: falling edge, MOSI advances here only.
              lcd_sclk_o <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state      <= FINISH;
                lcd_cs_o   <= 1'b1;
                bus.done_o <= 2'b10;
              end else begin
                bit_cnt    <= bit_cnt + 3'd1;
                lcd_mosi_o <= shreg[7];
                shreg      <= {shreg[6:0], 1'b0};
              end
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_SPI_BUSY_EN
  assign busy_o = busy;
`endif

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Self-checking bench for lcd_spi_writer (RST_LOW_CYC=4, RST_WAIT_CYC=8,
// CLK_DIV=2). Inputs change 1 time unit after a rising edge; outputs are
// read at the same point, so they show the values registered on that edge.
module tb_lcd_spi_writer;

  logic clk = 1'b0;
  logic rst;
  logic lcd_rst_o, lcd_cs_o, lcd_dc_o, lcd_sclk_o, lcd_mosi_o;
`ifdef LCD_SPI_BUSY_EN
  logic busy_o;
`endif

  lcd_spi_writer_if bus ();

  lcd_spi_writer #(
    .CLK_DIV      (2),
    .RST_LOW_CYC  (4),
    .RST_WAIT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
`ifdef LCD_SPI_BUSY_EN
    .busy_o     (busy_o),
`endif
    .lcd_rst_o  (lcd_rst_o),
    .lcd_cs_o   (lcd_cs_o),
    .lcd_dc_o   (lcd_dc_o),
    .lcd_sclk_o (lcd_sclk_o),
    .lcd_mosi_o (lcd_mosi_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] data;
    logic [1:0] inj_en;
    int         inj_cyc;
    logic       exp_dc;
    logic [7:0] exp_byte;
    int         exp_lat;
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one write and follow it to done_o[1], optionally pulsing another
  // request at cycle inj_cyc (cycle 1 = first cycle after the request edge).
  task automatic do_write(input logic [8:0] d, input logic [1:0] inj_en, input int inj_cyc,
                          output logic [7:0] byte_q, output int lat, output int rises,
                          output bit cs_ok, output bit rst_ok, output bit busy_ok);
    logic prev;
    byte_q = '0; lat = -1; rises = 0; cs_ok = 1; rst_ok = 1; busy_ok = 1; prev = 1'b0;
    bus.en_i = 2'b10; bus.data_i = d;
    step();
    bus.en_i = 2'b00;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (lcd_rst_o !== 1'b1) rst_ok = 0;
`ifdef LCD_SPI_BUSY_EN
      if (busy_o !== 1'b1) busy_ok = 0;
`endif
      if (bus.done_o[1] === 1'b1) begin
        lat = cyc;
        break;
      end
      if (lcd_cs_o !== 1'b0) cs_ok = 0;
      if (lcd_sclk_o === 1'b1 && prev === 1'b0) begin
        byte_q = {byte_q[6:0], lcd_mosi_o};
        rises++;
      end
      prev = lcd_sclk_o;
      if (cyc == inj_cyc) begin
        bus.en_i = inj_en; bus.data_i = 9'h0FF;
      end
      step();
      bus.en_i = 2'b00;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] b;
    int lat, rises, extra_done;
    bit cs_ok, rst_ok, busy_ok;
    do_write(v.data, v.inj_en, v.inj_cyc, b, lat, rises, cs_ok, rst_ok, busy_ok);
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_byte"}, b, v.exp_byte);
    chk({tag, "_rises"}, rises, 8);
    chk({tag, "_dc"}, lcd_dc_o, v.exp_dc);
    chk({tag, "_cs_low"}, cs_ok, 1);
    chk({tag, "_lcd_rst_high"}, rst_ok, 1);
    chk({tag, "_finish_cs_sclk"}, {lcd_cs_o, lcd_sclk_o}, 2'b10);
`ifdef LCD_SPI_BUSY_EN
    chk({tag, "_busy_during"}, busy_ok, 1);
`endif
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.done_o !== 2'b00) extra_done++;
      if (lcd_rst_o !== 1'b1 || lcd_cs_o !== 1'b1 || lcd_sclk_o !== 1'b0) extra_done++;
    end
    chk({tag, "_quiet_after"}, extra_done, 0);
    chk({tag, "_dc_hold"}, lcd_dc_o, v.exp_dc);
`ifdef LCD_SPI_BUSY_EN
    chk({tag, "_busy_idle"}, busy_o, 0);
`endif
  endtask

  // Reset sequence: lcd_rst_o low on cycles 1..4, high 5..12, done_o[0] on 13.
  task automatic run_reset_seq(input logic [1:0] en, input logic [8:0] d, input string tag);
    int low_cnt, first_low, done_cyc, done0, done1, spi_bad;
    low_cnt = 0; first_low = -1; done_cyc = -1; done0 = 0; done1 = 0; spi_bad = 0;
    bus.en_i = en; bus.data_i = d;
    step();
    bus.en_i = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      if (lcd_rst_o === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (bus.done_o[0] === 1'b1) begin done0++; done_cyc = c; end
      if (bus.done_o[1] !== 1'b0) done1++;
      if (lcd_sclk_o !== 1'b0 || lcd_cs_o !== 1'b1) spi_bad++;
`ifdef LCD_SPI_BUSY_EN
      if (busy_o !== ((c <= 12) ? 1'b1 : 1'b0)) spi_bad++;
`endif
      step();
    end
    chk({tag, "_low_start"}, first_low, 1);
    chk({tag, "_low_cycles"}, low_cnt, 4);
    chk({tag, "_done_cycle"}, done_cyc, 13);
    chk({tag, "_done0_count"}, done0, 1);
    chk({tag, "_no_write_done"}, done1, 0);
    chk({tag, "_spi_quiet"}, spi_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n_done, guard;
    logic [7:0] b;
    int lat;
    bit cs_ok, rst_ok, busy_ok;

    tbl[0] = '{9'h12C, 2'b00, -1, 1'b1, 8'h2C, 33};
    tbl[1] = '{9'h0A5, 2'b10, 10, 1'b0, 8'hA5, 33};
    tbl[2] = '{9'h1FF, 2'b01, 20, 1'b1, 8'hFF, 33};
    tbl[3] = '{9'h000, 2'b11, 5,  1'b0, 8'h00, 33};
    tbl[4] = '{9'h181, 2'b00, -1, 1'b1, 8'h81, 33};

    rst = 1'b1; bus.en_i = 2'b00; bus.data_i = '0;
    repeat (3) step();
    chk("reset_outputs", {lcd_rst_o, lcd_cs_o, lcd_sclk_o, lcd_mosi_o, lcd_dc_o, bus.done_o},
        7'b1100000);
    rst = 1'b0;
    step();
    chk("idle_outputs", {lcd_rst_o, lcd_cs_o, lcd_sclk_o, bus.done_o}, 5'b11000);
`ifdef LCD_SPI_BUSY_EN
    chk("idle_busy", busy_o, 0);
`endif

    run_reset_seq(2'b01, 9'h000, "rstseq");

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("wr%0d", i));

    // Simultaneous requests: only the reset sequence runs.
    run_reset_seq(2'b11, 9'h1AA, "both");
    chk("both_dc_unchanged", lcd_dc_o, 1'b1);

    // Back-to-back: request on FINISH ignored, on the first IDLE cycle accepted.
    do_write(9'h081, 2'b00, -1, b, lat, rises, cs_ok, rst_ok, busy_ok);
    chk("b2b_first_latency", lat, 33);
    bus.en_i = 2'b10; bus.data_i = 9'h1F0;
    step();
    chk("b2b_finish_ignored", lcd_cs_o, 1'b1);
    step();
    bus.en_i = 2'b00;
    chk("b2b_idle_accepted", {lcd_cs_o, lcd_dc_o, lcd_mosi_o, lcd_sclk_o}, 4'b0110);
    n_done = 0; guard = 0;
    while (n_done == 0 && guard < 60) begin
      step(); guard++;
      if (bus.done_o[1] === 1'b1) n_done++;
    end
    chk("b2b_second_latency", guard + 1, 33);
    repeat (3) step();

    // Reset asserted in the 3rd SCLK high phase aborts the transfer.
    bus.en_i = 2'b10; bus.data_i = 9'h1C3;
    step();
    bus.en_i = 2'b00;
    rises = 0; guard = 0;
    while (rises < 3 && guard < 60) begin
      if (lcd_sclk_o === 1'b1 && lcd_mosi_o !== 1'bx) begin
        rises++;
        if (rises < 3) while (lcd_sclk_o === 1'b1 && guard < 60) begin step(); guard++; end
      end else begin
        step(); guard++;
      end
    end
    chk("abort_reached_3rd_high", rises, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outputs", {lcd_cs_o, lcd_sclk_o, lcd_rst_o, bus.done_o, lcd_dc_o, lcd_mosi_o},
        7'b1010000);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done_o !== 2'b00 || lcd_cs_o !== 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_vec(tbl[0], "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
